// File: rtl/eth_tx_sched.sv
// Round-robin scheduler that feeds two payload sources into one UDP transmitter.
// Each packet takes the form: latch length/port, stream bytes on tx_clken_i, then hold the grant through a fixed gap.
`timescale 1ns/1ps

// state    | meaning
// ST_IDLE  | no grant; pick a requester, or reject an illegal length
// ST_START | tx_start_o high, waiting for the transmitter to take byte 1
// ST_DATA  | streaming the remaining bytes, one per tx_clken_i
// ST_GAP   | grant held while the transmitter sends FCS, idle and preamble
module eth_tx_sched #(
   parameter int GAP_CYCLES = 200,
   parameter int MAX_LEN    = 1472
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic [1:0]  req_i,
   input  logic [15:0] len0_i,
   input  logic [15:0] len1_i,
   input  logic [15:0] port0_i,
   input  logic [15:0] port1_i,
   input  logic [7:0]  data0_i,
   input  logic [7:0]  data1_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  rd_o,
   output logic [1:0]  done_o,
   output logic [1:0]  rej_o,
   output logic        tx_start_o,
   output logic [15:0] tx_len_o,
   output logic [15:0] tx_port_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_clken_i,
   output logic        busy_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam int              GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);

   logic [1:0]       state;
   logic [15:0]      byte_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             last_src;
   logic [1:0]       rej_mask;

   logic [1:0]  eligible;
   logic        sel_valid;
   logic        sel_src;
   logic [1:0]  sel_oh;
   logic [15:0] sel_len;
   logic [15:0] sel_port;
   logic        sel_legal;
   logic        xfer;
   logic        byte_take;
   logic        last_byte;

   // A rejected source stays masked until it drops its request, so a held
   // illegal request produces one rej_o pulse rather than one per cycle.
   assign eligible = req_i & ~rej_mask;
   assign sel_valid = |eligible;

   always_comb begin
      sel_src = 1'b0;
      if (eligible == 2'b11) begin
         sel_src = ~last_src;
      end else begin
         sel_src = eligible[1];
      end
   end

   assign sel_oh    = sel_src ? 2'b10 : 2'b01;
   assign sel_len   = sel_src ? len1_i : len0_i;
   assign sel_port  = sel_src ? port1_i : port0_i;
   assign sel_legal = (sel_len != 16'd0) && (sel_len <= MAX_LEN_W);

   assign xfer      = (state == ST_START) || (state == ST_DATA);
   assign byte_take = xfer && tx_clken_i;
   assign last_byte = byte_take && ((byte_cnt + 16'd1) == tx_len_o);

   assign rd_o       = {2{byte_take}} & gnt_o;
   assign done_o     = {2{last_byte}} & gnt_o;
   assign tx_start_o = (state == ST_START);
   assign busy_o     = (state != ST_IDLE);

   always_comb begin
      tx_data_o = 8'h00;
      if (gnt_o[0]) begin
         tx_data_o = data0_i;
      end else if (gnt_o[1]) begin
         tx_data_o = data1_i;
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state     <= ST_IDLE;
         gnt_o     <= 2'b00;
         rej_o     <= 2'b00;
         tx_len_o  <= 16'd0;
         tx_port_o <= 16'd0;
         byte_cnt  <= 16'd0;
         gap_cnt   <= '0;
         last_src  <= 1'b1;
         rej_mask  <= 2'b00;
      end else begin
         rej_o    <= 2'b00;
         rej_mask <= rej_mask & req_i;
         case (state)
            ST_IDLE: begin
               if (sel_valid) begin
                  if (sel_legal) begin
                     tx_len_o  <= sel_len;
                     tx_port_o <= sel_port;
                     gnt_o     <= sel_oh;
                     last_src  <= sel_src;
                     byte_cnt  <= 16'd0;
                     state     <= ST_START;
                  end else begin
                     rej_o    <= sel_oh;
                     rej_mask <= (rej_mask & req_i) | sel_oh;
                  end
               end
            end
            ST_START, ST_DATA: begin
               if (byte_take) begin
                  byte_cnt <= byte_cnt + 16'd1;
                  if (last_byte) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= ST_GAP;
                  end else begin
                     state   <= ST_DATA;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  gnt_o    <= 2'b00;
                  byte_cnt <= 16'd0;
                  state    <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: table of single-packet vectors, then reset-mid-packet and alternation sequences.
// Completed packets are checked against a queue of expected {source, length, port} records.
`timescale 1ns/1ps

module tb_eth_tx_sched;

   localparam int GAP = 8;
   localparam int MAXL = 1472;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [1:0]  req_i;
   logic [15:0] len0_i, len1_i, port0_i, port1_i;
   logic [7:0]  data0_i, data1_i;
   logic [1:0]  gnt_o, rd_o, done_o, rej_o;
   logic        tx_start_o;
   logic [15:0] tx_len_o, tx_port_o;
   logic [7:0]  tx_data_o;
   logic        tx_clken_i;
   logic        busy_o;

   eth_tx_sched #(.GAP_CYCLES(GAP), .MAX_LEN(MAXL)) dut (
      .clk        (clk),
      .reset_i    (reset_i),
      .req_i      (req_i),
      .len0_i     (len0_i),
      .len1_i     (len1_i),
      .port0_i    (port0_i),
      .port1_i    (port1_i),
      .data0_i    (data0_i),
      .data1_i    (data1_i),
      .gnt_o      (gnt_o),
      .rd_o       (rd_o),
      .done_o     (done_o),
      .rej_o      (rej_o),
      .tx_start_o (tx_start_o),
      .tx_len_o   (tx_len_o),
      .tx_port_o  (tx_port_o),
      .tx_data_o  (tx_data_o),
      .tx_clken_i (tx_clken_i),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [15:0] len;
      logic [15:0] port;
      int          period;
      bit          legal;
   } vec_t;

   typedef struct {
      int          src;
      logic [15:0] len;
      logic [15:0] port;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   mon_bytes = 0;
   logic [15:0] last_len = 16'd0;
   logic [15:0] last_port = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh(input int s);
      return (s == 1) ? 2'b10 : 2'b01;
   endfunction

   // scoreboard consumer: every done pulse retires one expected packet
   always @(negedge clk) begin
      if (reset_i) begin
         mon_bytes = 0;
      end else begin
         if (rd_o != 2'b00) mon_bytes++;
         if (done_o != 2'b00) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_done", 32'(done_o), 32'(0));
            end else begin
               mon_e = sb.pop_front();
               chk("sb_done_src", 32'(done_o), 32'(oh(mon_e.src)));
               chk("sb_len", 32'(tx_len_o), 32'(mon_e.len));
               chk("sb_port", 32'(tx_port_o), 32'(mon_e.port));
               chk("sb_bytes", 32'(mon_bytes), 32'(mon_e.len));
            end
            mon_bytes = 0;
         end
      end
   end

   task automatic run_legal(input vec_t v);
      logic [1:0] o;
      logic [7:0] exp_d;
      o = oh(v.src);
      if (v.src == 0) begin len0_i = v.len; port0_i = v.port; end
      else begin len1_i = v.len; port1_i = v.port; end
      req_i = o;
      tx_clken_i = 1'b0;
      sb.push_back('{v.src, v.len, v.port});
      @(posedge clk); #1;
      chk("start_gnt", 32'(gnt_o), 32'(o));
      chk("start_len", 32'(tx_len_o), 32'(v.len));
      chk("start_port", 32'(tx_port_o), 32'(v.port));
      chk("start_strobe", 32'(tx_start_o), 32'(1));
      chk("start_busy", 32'(busy_o), 32'(1));
      req_i = 2'b00;
      len0_i = 16'd7; len1_i = 16'd9; port0_i = 16'h9999; port1_i = 16'h7777;
      for (int b = 1; b <= int'(v.len); b++) begin
         for (int w = 0; w < v.period - 1; w++) begin
            tx_clken_i = 1'b0;
            data0_i = 8'($urandom); data1_i = 8'($urandom);
            exp_d = (v.src == 1) ? data1_i : data0_i;
            @(negedge clk);
            chk("wait_rd", 32'(rd_o), 32'(0));
            chk("wait_start", 32'(tx_start_o), 32'(b == 1));
            chk("wait_data", 32'(tx_data_o), 32'(exp_d));
            @(posedge clk); #1;
         end
         tx_clken_i = 1'b1;
         data0_i = 8'($urandom); data1_i = 8'($urandom);
         exp_d = (v.src == 1) ? data1_i : data0_i;
         @(negedge clk);
         chk("byte_rd", 32'(rd_o), 32'(o));
         chk("byte_start", 32'(tx_start_o), 32'(b == 1));
         chk("byte_done", 32'(done_o), 32'((b == int'(v.len)) ? o : 2'b00));
         chk("byte_data", 32'(tx_data_o), 32'(exp_d));
         @(posedge clk); #1;
      end
      for (int g = 0; g < GAP; g++) begin
         tx_clken_i = g[0];
         req_i = (g < GAP - 1) ? 2'b11 : 2'b00;
         @(negedge clk);
         chk("gap_gnt", 32'(gnt_o), 32'(o));
         chk("gap_busy", 32'(busy_o), 32'(1));
         chk("gap_rd", 32'(rd_o), 32'(0));
         chk("gap_done", 32'(done_o), 32'(0));
         chk("gap_start", 32'(tx_start_o), 32'(0));
         @(posedge clk); #1;
      end
      tx_clken_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_gnt", 32'(gnt_o), 32'(0));
         chk("idle_busy", 32'(busy_o), 32'(0));
         chk("idle_rd", 32'(rd_o), 32'(0));
         chk("idle_data", 32'(tx_data_o), 32'(0));
         chk("idle_hold_len", 32'(tx_len_o), 32'(v.len));
         chk("idle_hold_port", 32'(tx_port_o), 32'(v.port));
         @(posedge clk); #1;
      end
      tx_clken_i = 1'b0;
      last_len = v.len;
      last_port = v.port;
   endtask

   task automatic run_illegal(input vec_t v);
      logic [1:0] o;
      o = oh(v.src);
      if (v.src == 0) begin len0_i = v.len; port0_i = v.port; end
      else begin len1_i = v.len; port1_i = v.port; end
      req_i = o;
      @(posedge clk); #1;
      chk("rej_pulse", 32'(rej_o), 32'(o));
      chk("rej_busy", 32'(busy_o), 32'(0));
      chk("rej_start", 32'(tx_start_o), 32'(0));
      chk("rej_gnt", 32'(gnt_o), 32'(0));
      chk("rej_hold_len", 32'(tx_len_o), 32'(last_len));
      chk("rej_hold_port", 32'(tx_port_o), 32'(last_port));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rej_once", 32'(rej_o), 32'(0));
         chk("rej_busy_after", 32'(busy_o), 32'(0));
         chk("rej_start_after", 32'(tx_start_o), 32'(0));
      end
      req_i = 2'b00;
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vecs[8];
      int   starts;
      int   overlap;
      int   budget;
      logic [1:0] seq[4];

      vecs[0] = '{0, 16'd4,    16'h1234, 2, 1'b1};
      vecs[1] = '{1, 16'd3,    16'h0050, 1, 1'b1};
      vecs[2] = '{0, 16'd1,    16'h0007, 3, 1'b1};
      vecs[3] = '{1, 16'd0,    16'h0001, 1, 1'b0};
      vecs[4] = '{1, 16'd1473, 16'h0002, 1, 1'b0};
      vecs[5] = '{0, 16'd1472, 16'hABCD, 1, 1'b1};
      vecs[6] = '{1, 16'd2,    16'hFFFF, 1, 1'b1};
      vecs[7] = '{0, 16'd0,    16'h0003, 1, 1'b0};

      reset_i = 1'b1; req_i = 2'b00; tx_clken_i = 1'b0;
      len0_i = 16'd0; len1_i = 16'd0; port0_i = 16'd0; port1_i = 16'd0;
      data0_i = 8'h5A; data1_i = 8'hC3;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt_o), 32'(0));
      chk("rst_busy", 32'(busy_o), 32'(0));
      chk("rst_start", 32'(tx_start_o), 32'(0));
      chk("rst_len", 32'(tx_len_o), 32'(0));
      chk("rst_port", 32'(tx_port_o), 32'(0));
      chk("rst_data", 32'(tx_data_o), 32'(0));
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].legal) run_legal(vecs[i]);
         else run_illegal(vecs[i]);
      end

      // reset in the middle of a 10-byte packet, then fair alternation from a clean pointer
      len0_i = 16'd10; port0_i = 16'hBEEF; req_i = 2'b01; tx_clken_i = 1'b0;
      sb.push_back('{0, 16'd10, 16'hBEEF});
      @(posedge clk); #1;
      req_i = 2'b00; tx_clken_i = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_busy", 32'(busy_o), 32'(1));
      #2 reset_i = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt_o), 32'(0));
      chk("arst_rd", 32'(rd_o), 32'(0));
      chk("arst_done", 32'(done_o), 32'(0));
      chk("arst_rej", 32'(rej_o), 32'(0));
      chk("arst_start", 32'(tx_start_o), 32'(0));
      chk("arst_len", 32'(tx_len_o), 32'(0));
      chk("arst_port", 32'(tx_port_o), 32'(0));
      chk("arst_busy", 32'(busy_o), 32'(0));
      chk("arst_data", 32'(tx_data_o), 32'(0));
      sb.delete();
      @(posedge clk); #1;
      reset_i = 1'b0;
      len0_i = 16'd2; len1_i = 16'd2; port0_i = 16'h0A0A; port1_i = 16'h0B0B;
      req_i = 2'b11; tx_clken_i = 1'b1;
      sb.push_back('{0, 16'd2, 16'h0A0A});
      sb.push_back('{1, 16'd2, 16'h0B0B});
      sb.push_back('{0, 16'd2, 16'h0A0A});
      sb.push_back('{1, 16'd2, 16'h0B0B});
      starts = 0; overlap = 0; budget = 0;
      for (int k = 0; k < 4; k++) seq[k] = 2'b00;
      while (!(starts >= 4 && busy_o == 1'b0) && budget < 200) begin
         @(negedge clk);
         if ($countones(gnt_o) > 1) overlap++;
         if (tx_start_o) begin
            if (starts < 4) seq[starts] = gnt_o;
            starts++;
         end
         @(posedge clk); #1;
         if (starts >= 4) req_i = 2'b00;
         budget++;
      end
      chk("alt_count", 32'(starts), 32'(4));
      chk("alt_grant0", 32'(seq[0]), 32'(2'b01));
      chk("alt_grant1", 32'(seq[1]), 32'(2'b10));
      chk("alt_grant2", 32'(seq[2]), 32'(2'b01));
      chk("alt_grant3", 32'(seq[3]), 32'(2'b10));
      chk("alt_overlap", 32'(overlap), 32'(0));
      tx_clken_i = 1'b0;
      repeat (2) @(posedge clk);
      chk("sb_drained", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
